// File: rtl/nibble_pkg.sv
// Shared types and defaults for the nibble serializer path.
package nibble_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        NS_IDLE  = 2'd0,
        NS_CLEAR = 2'd1,
        NS_SHIFT = 2'd2
    } ns_state_t;

endpackage

// File: rtl/nibble_shift_reg.sv
// WIDTH-bit load/shift-left register with zero fill and MSB tap.
module nibble_shift_reg
    import nibble_pkg::*;
#(
    parameter int WIDTH = NIBBLE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    // A load on the last-bit cycle must win over that cycle's shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/nibble_serializer.sv
// Serializes word pairs (A, B) MSB-first on two lock-step lines.
// NIBBLE_SER_CLEAR_EN adds a one-cycle ns_clear pulse ahead of each frame.
module nibble_serializer
    import nibble_pkg::*;
#(
    parameter int WIDTH = NIBBLE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ns_valid,
    input  logic [WIDTH-1:0] ns_a,
    input  logic [WIDTH-1:0] ns_b,
    output logic             ns_ready,
    output logic             ns_bit_a,
    output logic             ns_bit_b,
    output logic             ns_bit_valid,
    output logic             ns_first,
    output logic             ns_last,
    output logic             ns_busy
`ifdef NIBBLE_SER_CLEAR_EN
    ,
    output logic             ns_clear
`endif
);

    localparam int CW = $clog2(WIDTH);

    ns_state_t     state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          shift_en;
    logic          msb_a;
    logic          msb_b;

    assign ns_ready = !reset && ((state == NS_IDLE) || ((state == NS_SHIFT) && (cnt == '0)));
    assign accept   = ns_valid && ns_ready;
    assign shift_en = (state == NS_SHIFT);

    nibble_shift_reg #(.WIDTH(WIDTH)) u_sa (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (shift_en),
        .din   (ns_a),
        .msb   (msb_a)
    );

    nibble_shift_reg #(.WIDTH(WIDTH)) u_sb (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (shift_en),
        .din   (ns_b),
        .msb   (msb_b)
    );

    // Registered flags are set for the state being entered, so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= NS_IDLE;
            cnt          <= '0;
            ns_bit_valid <= 1'b0;
            ns_first     <= 1'b0;
            ns_last      <= 1'b0;
            ns_busy      <= 1'b0;
`ifdef NIBBLE_SER_CLEAR_EN
            ns_clear     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                cnt     <= CW'(WIDTH - 1);
                ns_busy <= 1'b1;
                ns_last <= 1'b0;
`ifdef NIBBLE_SER_CLEAR_EN
                state        <= NS_CLEAR;
                ns_clear     <= 1'b1;
                ns_bit_valid <= 1'b0;
                ns_first     <= 1'b0;
`else
                state        <= NS_SHIFT;
                ns_bit_valid <= 1'b1;
                ns_first     <= 1'b1;
`endif
            end else begin
                case (state)
                    NS_CLEAR: begin
                        state        <= NS_SHIFT;
                        ns_bit_valid <= 1'b1;
                        ns_first     <= 1'b1;
                        ns_last      <= 1'b0;
                        ns_busy      <= 1'b1;
`ifdef NIBBLE_SER_CLEAR_EN
                        ns_clear     <= 1'b0;
`endif
                    end
                    NS_SHIFT: begin
                        if (cnt == '0) begin
                            state        <= NS_IDLE;
                            ns_bit_valid <= 1'b0;
                            ns_first     <= 1'b0;
                            ns_last      <= 1'b0;
                            ns_busy      <= 1'b0;
                        end else begin
                            cnt      <= cnt - 1'b1;
                            ns_first <= 1'b0;
                            ns_last  <= (cnt == CW'(1));
                        end
                    end
                    default: begin
                        state        <= NS_IDLE;
                        ns_bit_valid <= 1'b0;
                        ns_first     <= 1'b0;
                        ns_last      <= 1'b0;
                        ns_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Shift registers still hold the word during CLEAR, so gate the taps.
    assign ns_bit_a = msb_a && ns_bit_valid;
    assign ns_bit_b = msb_b && ns_bit_valid;

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer (WIDTH=4); follows NIBBLE_SER_CLEAR_EN if defined.
module tb_nibble_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ns_valid = 1'b0;
    logic [3:0] ns_a = '0;
    logic [3:0] ns_b = '0;
    logic       ns_ready, ns_bit_a, ns_bit_b, ns_bit_valid, ns_first, ns_last, ns_busy;
    logic       clr;
    logic [7:0] obs;
    logic [7:0] exp_v;
    int         errors = 0;
    int         checks = 0;

    localparam logic [7:0] V_RST   = 8'b0000_0000;
    localparam logic [7:0] V_IDLE  = 8'b1000_0000;
    localparam logic [7:0] V_CLEAR = 8'b0000_0011;

    always #5 clk = ~clk;

    nibble_serializer #(.WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ns_valid     (ns_valid),
        .ns_a         (ns_a),
        .ns_b         (ns_b),
        .ns_ready     (ns_ready),
        .ns_bit_a     (ns_bit_a),
        .ns_bit_b     (ns_bit_b),
        .ns_bit_valid (ns_bit_valid),
        .ns_first     (ns_first),
        .ns_last      (ns_last),
        .ns_busy      (ns_busy)
`ifdef NIBBLE_SER_CLEAR_EN
        ,
        .ns_clear     (clr)
`endif
    );

`ifndef NIBBLE_SER_CLEAR_EN
    assign clr = 1'b0;
`endif

    // {ready, bit_valid, bit_a, bit_b, first, last, busy, clear}
    assign obs = {ns_ready, ns_bit_valid, ns_bit_a, ns_bit_b, ns_first, ns_last, ns_busy, clr};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ns_valid = 1'b1;
        ns_a = 4'hA;
        ns_b = 4'h5;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== V_RST) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, V_RST);
            end
        end
        ns_valid = 1'b0;
        reset = 1'b0;
        step();
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs, V_IDLE);
        end
    endtask

    task automatic test_frame();
        logic [3:0] ea = 4'b1010;
        logic [3:0] eb = 4'b0110;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL frame_idle: got %b expected %b", obs, V_IDLE);
        end
        ns_valid = 1'b1;
        ns_a = ea;
        ns_b = eb;
`ifdef NIBBLE_SER_CLEAR_EN
        step();
        ns_valid = 1'b0;
        checks++;
        if (obs !== V_CLEAR) begin
            errors++;
            $display("FAIL frame_clear: got %b expected %b", obs, V_CLEAR);
        end
`endif
        for (int j = 0; j < 4; j++) begin
            step();
            ns_valid = 1'b0;
            exp_v = {(j == 3), 1'b1, ea[3-j], eb[3-j], (j == 0), (j == 3), 1'b1, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL frame_bit[%0d]: got %b expected %b", j, obs, exp_v);
            end
        end
        step();
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL frame_end_idle: got %b expected %b", obs, V_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] fa [2];
        logic [3:0] fb [2];
        fa[0] = 4'hF; fb[0] = 4'h0;
        fa[1] = 4'h3; fb[1] = 4'h3;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL b2b_idle: got %b expected %b", obs, V_IDLE);
        end
        ns_valid = 1'b1;
        ns_a = fa[0];
        ns_b = fb[0];
        for (int f = 0; f < 2; f++) begin
`ifdef NIBBLE_SER_CLEAR_EN
            step();
            ns_a = fa[1];
            ns_b = fb[1];
            checks++;
            if (obs !== V_CLEAR) begin
                errors++;
                $display("FAIL b2b_clear[%0d]: got %b expected %b", f, obs, V_CLEAR);
            end
`endif
            for (int j = 0; j < 4; j++) begin
                step();
                ns_a = fa[1];
                ns_b = fb[1];
                if (f == 1 && j == 3) ns_valid = 1'b0;
                exp_v = {(j == 3), 1'b1, fa[f][3-j], fb[f][3-j], (j == 0), (j == 3), 1'b1, 1'b0};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_bit[%0d][%0d]: got %b expected %b", f, j, obs, exp_v);
                end
            end
        end
        step();
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL b2b_end_idle: got %b expected %b", obs, V_IDLE);
        end
    endtask

    task automatic test_valid_mid_frame();
        logic [3:0] fa [2];
        logic [3:0] fb [2];
        fa[0] = 4'b1100; fb[0] = 4'b0011;
        fa[1] = 4'b0101; fb[1] = 4'b1001;
        ns_valid = 1'b1;
        ns_a = fa[0];
        ns_b = fb[0];
        for (int f = 0; f < 2; f++) begin
`ifdef NIBBLE_SER_CLEAR_EN
            step();
            ns_valid = 1'b0;
            checks++;
            if (obs !== V_CLEAR) begin
                errors++;
                $display("FAIL mid_clear[%0d]: got %b expected %b", f, obs, V_CLEAR);
            end
`endif
            for (int j = 0; j < 4; j++) begin
                step();
                ns_valid = 1'b0;
                if (f == 0 && j >= 1) begin
                    ns_valid = 1'b1;
                    ns_a = fa[1];
                    ns_b = fb[1];
                end
                exp_v = {(j == 3), 1'b1, fa[f][3-j], fb[f][3-j], (j == 0), (j == 3), 1'b1, 1'b0};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL mid_bit[%0d][%0d]: got %b expected %b", f, j, obs, exp_v);
                end
            end
        end
        step();
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL mid_end_idle: got %b expected %b", obs, V_IDLE);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] ea = 4'b1011;
        logic [3:0] eb = 4'b0100;
        logic [3:0] na = 4'b0110;
        logic [3:0] nb = 4'b1001;
        ns_valid = 1'b1;
        ns_a = ea;
        ns_b = eb;
`ifdef NIBBLE_SER_CLEAR_EN
        step();
        ns_valid = 1'b0;
`endif
        for (int j = 0; j < 2; j++) begin
            step();
            ns_valid = 1'b0;
            exp_v = {1'b0, 1'b1, ea[3-j], eb[3-j], (j == 0), 1'b0, 1'b1, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rstmid_bit[%0d]: got %b expected %b", j, obs, exp_v);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ns_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready_low: got %b expected 0", ns_ready);
        end
        step();
        reset = 1'b0;
        checks++;
        if (obs[6:0] !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_cleared: got %b expected 0000000", obs[6:0]);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (obs !== V_IDLE) begin
                errors++;
                $display("FAIL rstmid_idle[%0d]: got %b expected %b", k, obs, V_IDLE);
            end
        end
        ns_valid = 1'b1;
        ns_a = na;
        ns_b = nb;
`ifdef NIBBLE_SER_CLEAR_EN
        step();
        ns_valid = 1'b0;
        checks++;
        if (obs !== V_CLEAR) begin
            errors++;
            $display("FAIL rstmid_new_clear: got %b expected %b", obs, V_CLEAR);
        end
`endif
        for (int j = 0; j < 4; j++) begin
            step();
            ns_valid = 1'b0;
            exp_v = {(j == 3), 1'b1, na[3-j], nb[3-j], (j == 0), (j == 3), 1'b1, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rstmid_new_bit[%0d]: got %b expected %b", j, obs, exp_v);
            end
        end
        step();
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL rstmid_end_idle: got %b expected %b", obs, V_IDLE);
        end
    endtask

`ifdef NIBBLE_SER_CLEAR_EN
    task automatic test_clear_period();
        logic [1:0] pairs [4];
        int         last_clear;
        pairs[0] = 2'b11; pairs[1] = 2'b01; pairs[2] = 2'b00; pairs[3] = 2'b10;
        last_clear = -1;
        ns_valid = 1'b1;
        ns_a = 4'h9;
        ns_b = 4'hC;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 9) ns_valid = 1'b0;
            if ((c % 5) == 0) begin
                checks++;
                if (obs !== V_CLEAR) begin
                    errors++;
                    $display("FAIL clr_pulse[%0d]: got %b expected %b", c, obs, V_CLEAR);
                end
                if (clr === 1'b1 && last_clear >= 0) begin
                    checks++;
                    if (c - last_clear !== 5) begin
                        errors++;
                        $display("FAIL clr_period: got %0d expected 5", c - last_clear);
                    end
                end
                if (clr === 1'b1) last_clear = c;
            end else begin
                exp_v = {((c % 5) == 4), 1'b1, pairs[(c % 5) - 1], ((c % 5) == 1), ((c % 5) == 4), 1'b1, 1'b0};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL clr_bit[%0d]: got %b expected %b", c, obs, exp_v);
                end
            end
        end
        step();
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL clr_end_idle: got %b expected %b", obs, V_IDLE);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_valid_mid_frame();
        test_reset_mid_frame();
`ifdef NIBBLE_SER_CLEAR_EN
        test_clear_period();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
